ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command/data byte to the PS/2 keyboard, e.g. 0xED LED set or 0xFF reset.
- Counterpart to the existing device-to-host keyboard receiver; shares the ps2_clk/ps2_data open-drain pins with it.
- Runs in the pclk domain, next to the keyboard module in the arcade top level.
- Arbitration with the receiver is outside this block: while it is busy it owns the lines, and the receiver ignores frames while tx_busy=1.

Parameters:
- CLK_KHZ, 24390, system clock frequency in kHz (pclk = 50 MHz*20/41).
- INHIBIT_US, 100, time the host holds clock low before the request-to-send.
- TIMEOUT_MS, 15, maximum time from clock release to the ack before aborting.
- FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a line change.

Ports:
- clk  in  1  system clock (pclk)
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse at end of transaction
- tx_ack_ok  out  1  valid with tx_done; 1 = device acked, 0 = NAK or timeout
- ps2_clk_in  in  1  raw PS/2 clock pin level
- ps2_data_in  in  1  raw PS/2 data pin level
- ps2_clk_oe  out  1  1 = pull clock low; 0 = release
- ps2_data_oe  out  1  1 = pull data low; 0 = release

Behaviour:
- Reset values: state IDLE, tx_ready=1, tx_busy=0, tx_done=0, tx_ack_ok=0, ps2_clk_oe=0, ps2_data_oe=0, all counters 0. Filter outputs reset to 1.
- Input conditioning: each line passes through a 2-FF synchronizer, then a FILTER_LEN filter. The filtered output changes only after FILTER_LEN identical consecutive samples.
- fall = filtered clock 1->0, one-cycle strobe.
- Accept in IDLE on tx_valid: latch tx_data and parity = ~^tx_data (odd parity); clear bit_cnt and timer.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_US*CLK_KHZ/1000 cycles (2439 by default).
- REQ: one cycle; data_oe=1 (start bit), clk_oe=0; timer cleared; go to SEND.
- SEND, driven on fall edges:
  - Falls 1..8: data_oe = ~bit[fall-1], LSB first.
  - Fall 9: data_oe = ~parity.
  - Fall 10: data_oe=0 (stop); go to ACK.
  - bit_cnt is a 4-bit counter of falls.
- ACK: on the next fall, sample filtered data. 0 = ack_ok=1, 1 = ack_ok=0. Go to RELEASE.
- RELEASE: wait until filtered clock=1 and data=1 together, then go to DONE.
- DONE: one cycle; tx_done=1, tx_ack_ok=result; then IDLE.
- Timeout: timer runs from REQ through RELEASE. On reaching TIMEOUT_MS*CLK_KHZ (365850 cycles by default; counter 19 bits min):
  - release both lines immediately;
  - go to DONE with ack_ok=0.
- tx_valid is ignored while busy; there is no queueing.
- Reset asserted mid-frame: both oe outputs drop to 0 asynchronously, and the latched byte is discarded.
- A fall during INHIBIT or REQ (device contention) is ignored; the device must not clock while the host holds clock low.
- Exactly one tx_done pulse per accepted byte.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, DONE};
  - PS2_FRAME_FALLS=10 constant;
  - common command constants CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ACK=8'hFA.
- Sub-module ps2_line_filter (synchronizer + FILTER_LEN filter + fall strobe), instantiated twice.
- The existing receiver should adopt ps2_line_filter later.

Test Plan:
- tx_data=0x01 with a device model clocking at 12.5 kHz and acking:
  - bits on data after falls 1..10 = 1,0,0,0,0,0,0,0, parity 0, stop 1;
  - tx_done pulse with ack_ok=1; clk_oe held 2439±1 cycles beforehand.
- tx_data=0xED: data sequence 1,0,1,1,0,1,1,1, parity 1; ack_ok=1; tx_ready returns to 1 one cycle after tx_done.
- Device never clocks after REQ: at 365850 cycles both oe=0, tx_done=1, ack_ok=0.
- Device leaves data high at fall 11 (NAK): ack_ok=0; the block waits for both lines high before tx_done.
- Reset pulsed during SEND after fall 4: oe outputs drop to 0 with no clk edge needed. The next byte 0xFF sends parity 1 and completes with ack_ok=1.
- 3-cycle glitches on ps2_clk_in during SEND: no extra bits shifted, frame identical to the glitch-free run. tx_valid held high while busy does not start a second frame until IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame constants and
// common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    RELEASE,
    DONE
  } ps2_state_e;

  // Host-to-device frame: 8 data bits LSB first, odd parity, stop.
  localparam int unsigned PS2_FRAME_FALLS = 10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ACK     = 8'hFA;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-FF synchronizer, then a run-length filter
// that accepts a new level only after FILTER_LEN equal samples.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line,
  output logic fall
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync;
  logic             sample;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], line_in};
  end

  assign sample = sync[1];

  // Count consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sample == line) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        line <= sample;
        cnt  <= '0;
        fall <= ~sample;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a
// request-to-send, shifts one byte out on device clock falls, collects the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_KHZ    = 24390,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_MS = 15,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = INHIBIT_US * CLK_KHZ / 1000;
  localparam int unsigned TIMEOUT_CYC = TIMEOUT_MS * CLK_KHZ;
  localparam int unsigned TMR_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       FALLS_LAST   = 4'(PS2_FRAME_FALLS - 1);

  ps2_state_e       state, state_n;
  ps2_frame_t       frame, frame_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             ack_res, ack_res_n;
  logic             data_oe_n;

  logic clk_filt, clk_fall;
  logic data_filt, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .line    (clk_filt),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_data_in),
    .line    (data_filt),
    .fall    (data_fall_unused)
  );

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      ack_res     <= 1'b0;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_ack_ok   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      state       <= state_n;
      frame       <= frame_n;
      bit_cnt     <= bit_cnt_n;
      timer       <= timer_n;
      ack_res     <= ack_res_n;
      tx_ready    <= (state_n == IDLE);
      tx_busy     <= (state_n != IDLE);
      tx_done     <= (state_n == DONE);
      tx_ack_ok   <= (state_n == DONE) && ack_res_n;
      ps2_clk_oe  <= (state_n == INHIBIT);
      ps2_data_oe <= data_oe_n;
    end
  end

  // Next-state logic; data_oe_n is the data drive for the next state.
  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;
    timer_n   = timer;
    ack_res_n = ack_res;
    data_oe_n = ps2_data_oe;

    case (state)
      IDLE: begin
        data_oe_n = 1'b0;
        if (tx_valid) begin
          frame_n.data   = tx_data;
          frame_n.parity = odd_parity(tx_data);
          bit_cnt_n      = '0;
          timer_n        = '0;
          ack_res_n      = 1'b0;
          state_n        = INHIBIT;
        end
      end

      INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          timer_n   = '0;
          data_oe_n = 1'b1;
          state_n   = REQ;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end

      REQ: begin
        timer_n = TMR_W'(1);
        state_n = SEND;
      end

      SEND: begin
        timer_n = timer + TMR_W'(1);
        if (clk_fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8) begin
            data_oe_n = ~frame.data[bit_cnt[2:0]];
          end else if (bit_cnt < FALLS_LAST) begin
            data_oe_n = ~frame.parity;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end
      end

      ACK: begin
        timer_n = timer + TMR_W'(1);
        if (clk_fall) begin
          ack_res_n = ~data_filt;
          state_n   = RELEASE;
        end
      end

      RELEASE: begin
        timer_n = timer + TMR_W'(1);
        if (clk_filt && data_filt) state_n = DONE;
      end

      DONE: begin
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end

      default: begin
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase

    // A device that stops clocking must not hang the host.
    if ((state == SEND || state == ACK || state == RELEASE) && timer == TIMEOUT_LAST) begin
      ack_res_n = 1'b0;
      data_oe_n = 1'b0;
      state_n   = DONE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain device model clocking frames,
// plus a short-timeout instance for the no-clock abort case.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int H = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_ack_ok;
  logic       clk_oe, data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  ps2_host_tx dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  // Scaled-down instance (1 MHz): inhibit 100 cycles, timeout 15000 cycles.
  logic [7:0] t_data = 8'h00;
  logic       t_valid = 1'b0;
  logic       t_ready, t_busy, t_done, t_ack_ok, t_clk_oe, t_data_oe;
  logic       t_clk_line, t_data_line;

  assign t_clk_line  = ~t_clk_oe;
  assign t_data_line = ~t_data_oe;

  ps2_host_tx #(.CLK_KHZ(1000)) dut_to (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (t_data),
    .tx_valid    (t_valid),
    .tx_ready    (t_ready),
    .tx_busy     (t_busy),
    .tx_done     (t_done),
    .tx_ack_ok   (t_ack_ok),
    .ps2_clk_in  (t_clk_line),
    .ps2_data_in (t_data_line),
    .ps2_clk_oe  (t_clk_oe),
    .ps2_data_oe (t_data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_rises = 0;
  logic busy_q = 1'b0;

  always @(negedge clk) begin
    busy_q <= tx_busy;
    if (tx_busy && !busy_q) busy_rises <= busy_rises + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d, input bit hold_valid);
    int n;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_busy && n < 10) begin @(negedge clk); n++; end
    check("accept", tx_busy, 1);
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  // Device model: waits out the inhibit, then clocks 11 falls; data is read
  // just before each rising edge. stop_after>0 abandons the frame with clock low.
  task automatic device(input bit ack, input bit glitch, input int hold_low,
                        input int stop_after, output logic [9:0] bits, output int inh_len);
    int n, d0;
    bits = '0;
    inh_len = 0;
    n = 0;
    while (!clk_oe && n < 100) begin @(negedge clk); n++; end
    while (clk_oe && inh_len < 5000) begin @(negedge clk); inh_len++; end
    tick(30);
    check("start_bit", ps2_data_line, 0);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (glitch) begin
        tick(H / 2); dev_clk_low = 1'b0; tick(3); dev_clk_low = 1'b1; tick(H - H / 2 - 3);
      end else begin
        tick(H);
      end
      if (i == stop_after) return;
      if (i == 11 && hold_low > 0) begin
        d0 = done_cnt;
        tick(hold_low);
        check("hold_busy", tx_busy, 1);
        check("hold_no_done", 32'(done_cnt - d0), 0);
      end
      if (i <= 10) bits[i-1] = ps2_data_line;
      dev_clk_low = 1'b0;
      if (i == 11) begin
        dev_data_low = 1'b0;
        return;
      end
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (glitch) begin
        tick(H / 2); dev_clk_low = 1'b1; tick(3); dev_clk_low = 1'b0; tick(H - H / 2 - 3);
      end else begin
        tick(H);
      end
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_ack, input int budget);
    int n;
    n = 0;
    while (!tx_done && n < budget) begin @(negedge clk); n++; end
    tx_valid = 1'b0;
    check($sformatf("%s_done", tag), tx_done, 1);
    check($sformatf("%s_ack", tag), tx_ack_ok, exp_ack);
    check($sformatf("%s_ready_in_done", tag), tx_ready, 0);
    @(negedge clk);
    check($sformatf("%s_ready_after", tag), tx_ready, 1);
    check($sformatf("%s_done_pulse", tag), tx_done, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int inh, n, d0, b0;

    tick(3);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ack", tx_ack_ok, 0);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    reset = 1'b0;
    tick(20);

    // 0x01: bits 1,0,0,0,0,0,0,0, parity 0, stop 1
    start_tx(8'h01, 1'b0);
    device(1'b1, 1'b0, 0, 0, bits, inh);
    check("b01_inhibit_len", (inh >= 2438 && inh <= 2440), 1);
    check("b01_bits", bits, 10'h201);
    wait_done("b01", 1'b1, 100);
    tick(20);

    // 0xED LED command: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    start_tx(CMD_SET_LED, 1'b0);
    device(1'b1, 1'b0, 0, 0, bits, inh);
    check("ed_bits", bits, 10'h3ED);
    wait_done("ed", 1'b1, 100);
    tick(20);

    // NAK on 0x00 (parity 1); device keeps clock low after fall 11
    start_tx(8'h00, 1'b0);
    device(1'b0, 1'b0, 200, 0, bits, inh);
    check("nak_bits", bits, 10'h300);
    wait_done("nak", 1'b0, 100);
    tick(20);

    // Reset during SEND after fall 4; bit 3 of 0x01 is 0 so data is driven low
    start_tx(8'h01, 1'b0);
    device(1'b1, 1'b0, 0, 4, bits, inh);
    check("pre_rst_data_oe", data_oe, 1);
    check("pre_rst_clk_oe", clk_oe, 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_data_oe", data_oe, 0);
    check("async_rst_clk_oe", clk_oe, 0);
    check("async_rst_busy", tx_busy, 0);
    dev_clk_low = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    check("post_rst_ready", tx_ready, 1);

    start_tx(CMD_RESET, 1'b0);
    device(1'b1, 1'b0, 0, 0, bits, inh);
    check("ff_bits", bits, 10'h3FF);
    wait_done("ff", 1'b1, 100);
    tick(20);

    // Glitched device clock with tx_valid held high through the frame
    d0 = done_cnt;
    b0 = busy_rises;
    start_tx(CMD_SET_LED, 1'b1);
    device(1'b1, 1'b1, 0, 0, bits, inh);
    check("glitch_bits", bits, 10'h3ED);
    wait_done("glitch", 1'b1, 100);
    tick(3);
    check("glitch_one_frame", 32'(busy_rises - b0), 1);
    check("glitch_one_done", 32'(done_cnt - d0), 1);
    check("glitch_idle_after", tx_busy, 0);

    // Timeout on the scaled instance: no device clocking after the request
    @(negedge clk);
    t_data  = CMD_SET_LED;
    t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    inh = 0;
    while (t_clk_oe && inh < 1000) begin @(negedge clk); inh++; end
    check("to_inhibit_len", (inh >= 99 && inh <= 101), 1);
    n = 0;
    while (!t_data_oe && n < 10) begin @(negedge clk); n++; end
    check("to_req", t_data_oe, 1);
    n = 0;
    while (!t_done && n < 20000) begin @(negedge clk); n++; end
    check("to_done", t_done, 1);
    check("to_cycles", (n >= 14999 && n <= 15001), 1);
    check("to_ack", t_ack_ok, 0);
    check("to_clk_oe", t_clk_oe, 0);
    check("to_data_oe", t_data_oe, 0);
    @(negedge clk);
    check("to_ready_after", t_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
